// File: rtl/lram_pkg.sv
// Shared constants and FSM state type for the LUTRAM loader and its storage.
package lram_pkg;

  localparam int unsigned LRAM_DEPTH_MAX = 64;
  localparam int unsigned LRAM_AW        = 6;
  localparam int unsigned LRAM_DW        = 8;

  typedef enum logic [0:0] {LOAD, FULL} lram_ld_state_t;

endpackage

// File: rtl/lram_dp64x8.sv
// 64x8 simple dual-port distributed RAM: synchronous write, asynchronous read, no array reset.
module lram_dp64x8
  import lram_pkg::*;
(
  input  logic               clock,
  input  logic               we,
  input  logic [LRAM_AW-1:0] wr_addr,
  input  logic [LRAM_DW-1:0] wr_data,
  input  logic [LRAM_AW-1:0] rd_addr,
  output logic [LRAM_DW-1:0] rd_data
);

  logic [LRAM_DW-1:0] mem [LRAM_DEPTH_MAX];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Combinational read sees the old byte during the write cycle.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lram_loader.sv
// Loads a valid/ready byte stream into a 64x8 LUTRAM, raising loaded after DEPTH bytes.
// Optional running XOR checksum port when LRAM_LOADER_CHECKSUM_EN is defined.
module lram_loader
  import lram_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LRAM_DW-1:0] in_data,
  input  logic [LRAM_AW-1:0] rd_addr,
  output logic [LRAM_DW-1:0] rd_data,
  output logic               loaded,
  output logic [LRAM_AW:0]   count
`ifdef LRAM_LOADER_CHECKSUM_EN
  ,
  output logic [LRAM_DW-1:0] checksum
`endif
);

  localparam int unsigned CW = LRAM_AW + 1;
  localparam logic [CW-1:0] LastCount = CW'(DEPTH - 1);

  lram_ld_state_t     state_q, state_d;
  logic [LRAM_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               accept;

  // Gated by reset so nothing is written while the block is held in reset.
  assign in_ready = (state_q == LOAD) & ~clear & reset;
  assign accept   = in_valid & in_ready;
  assign loaded   = (state_q == FULL);
  assign count    = count_q;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      state_d  = LOAD;
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      count_d  = count_q + 1'b1;
      if (count_q == LastCount) begin
        state_d = FULL;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= LOAD;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef LRAM_LOADER_CHECKSUM_EN
  logic [LRAM_DW-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (clear) begin
      checksum_d = '0;
    end else if (accept) begin
      checksum_d = checksum_q ^ in_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`endif

  lram_dp64x8 u_mem (
    .clock   (clock),
    .we      (accept),
    .wr_addr (wr_ptr_q),
    .wr_data (in_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_lram_loader.sv
// Scoreboard bench for lram_loader: three instances (DEPTH 64, 8, 4) sharing clock and reset.
module tb_lram_loader;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic       clr64 = 0, v64 = 0, rdy64, ld64;
  logic [7:0] dat64 = 0, rd64;
  logic [5:0] ra64 = 0;
  logic [6:0] cnt64;
  logic       clr8 = 0, v8 = 0, rdy8, ld8;
  logic [7:0] dat8 = 0, rd8;
  logic [5:0] ra8 = 0;
  logic [6:0] cnt8;
  logic       clr4 = 0, v4 = 0, rdy4, ld4;
  logic [7:0] dat4 = 0, rd4;
  logic [5:0] ra4 = 0;
  logic [6:0] cnt4;
`ifdef LRAM_LOADER_CHECKSUM_EN
  logic [7:0] cs64, cs8, cs4;
`endif

  int         passed = 0;
  int         total = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_cs;
  logic [7:0] e;

  lram_loader #(.DEPTH(64)) u_d64 (
    .clock(clock), .reset(reset), .clear(clr64), .in_valid(v64), .in_ready(rdy64),
    .in_data(dat64), .rd_addr(ra64), .rd_data(rd64), .loaded(ld64), .count(cnt64)
`ifdef LRAM_LOADER_CHECKSUM_EN
    , .checksum(cs64)
`endif
  );

  lram_loader #(.DEPTH(8)) u_d8 (
    .clock(clock), .reset(reset), .clear(clr8), .in_valid(v8), .in_ready(rdy8),
    .in_data(dat8), .rd_addr(ra8), .rd_data(rd8), .loaded(ld8), .count(cnt8)
`ifdef LRAM_LOADER_CHECKSUM_EN
    , .checksum(cs8)
`endif
  );

  lram_loader #(.DEPTH(4)) u_d4 (
    .clock(clock), .reset(reset), .clear(clr4), .in_valid(v4), .in_ready(rdy4),
    .in_data(dat4), .rd_addr(ra4), .rd_data(rd4), .loaded(ld4), .count(cnt4)
`ifdef LRAM_LOADER_CHECKSUM_EN
    , .checksum(cs4)
`endif
  );

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    total++;
    if ({rdy64, rdy8, rdy4} !== 3'b000) $display("FAIL reset_ready_low got=%b want=000",
                                                 {rdy64, rdy8, rdy4});
    else passed++;
    @(posedge clock); #1; reset = 1'b1;
    @(negedge clock);
    total++;
    if ({rdy64, rdy8, rdy4} !== 3'b111 || {ld64, ld8, ld4} !== 3'b000)
      $display("FAIL reset_release ready=%b loaded=%b want 111/000",
               {rdy64, rdy8, rdy4}, {ld64, ld8, ld4});
    else passed++;
    total++;
    if (cnt64 !== 7'd0 || cnt8 !== 7'd0 || cnt4 !== 7'd0)
      $display("FAIL reset_count got=%0d/%0d/%0d want=0", cnt64, cnt8, cnt4);
    else passed++;
`ifdef LRAM_LOADER_CHECKSUM_EN
    total++;
    if (cs64 !== 8'h00 || cs8 !== 8'h00 || cs4 !== 8'h00)
      $display("FAIL reset_checksum got=%h/%h/%h want=00", cs64, cs8, cs4);
    else passed++;
`endif
  endtask

  task automatic test_full_load();
    model_cs = 8'h00;
    for (int i = 0; i < 64; i++) begin
      @(posedge clock); #1;
      v64 = 1'b1; dat64 = 8'(i);
      exp_q.push_back(8'(i));
      model_cs ^= 8'(i);
      if (i == 63) begin
        @(negedge clock);
        total++;
        if (ld64 !== 1'b0 || cnt64 !== 7'd63)
          $display("FAIL full_before_last loaded=%b count=%0d want 0/63", ld64, cnt64);
        else passed++;
      end
    end
    @(posedge clock); #1;
    v64 = 1'b0;
    total++;
    if (ld64 !== 1'b1 || cnt64 !== 7'd64 || rdy64 !== 1'b0)
      $display("FAIL full_done loaded=%b count=%0d ready=%b want 1/64/0", ld64, cnt64, rdy64);
    else passed++;
    for (int k = 0; k < 64; k++) begin
      ra64 = 6'(k); #1;
      e = exp_q.pop_front();
      total++;
      if (rd64 !== e) $display("FAIL full_read addr=%0d got=%h want=%h", k, rd64, e);
      else passed++;
    end
`ifdef LRAM_LOADER_CHECKSUM_EN
    total++;
    if (cs64 !== model_cs) $display("FAIL full_checksum got=%h want=%h", cs64, model_cs);
    else passed++;
`endif
  endtask

  task automatic test_backpressure();
    model_cs = 8'h00;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      v8 = 1'b1; dat8 = 8'hA0 + 8'(i);
      exp_q.push_back(8'hA0 + 8'(i));
      model_cs ^= 8'hA0 + 8'(i);
      @(posedge clock); #1;
      v8 = 1'b0; dat8 = 8'hFF;
    end
    total++;
    if (ld8 !== 1'b1 || cnt8 !== 7'd8)
      $display("FAIL bp_loaded loaded=%b count=%0d want 1/8", ld8, cnt8);
    else passed++;
    v8 = 1'b1; dat8 = 8'hA8;
    repeat (3) @(negedge clock);
    total++;
    if (rdy8 !== 1'b0) $display("FAIL bp_full_ready got=%b want=0", rdy8);
    else passed++;
    @(posedge clock); #1;
    v8 = 1'b0;
    total++;
    if (cnt8 !== 7'd8 || ld8 !== 1'b1)
      $display("FAIL bp_ninth_beat count=%0d loaded=%b want 8/1", cnt8, ld8);
    else passed++;
    for (int k = 0; k < 8; k++) begin
      ra8 = 6'(k); #1;
      e = exp_q.pop_front();
      total++;
      if (rd8 !== e) $display("FAIL bp_read addr=%0d got=%h want=%h", k, rd8, e);
      else passed++;
    end
`ifdef LRAM_LOADER_CHECKSUM_EN
    total++;
    if (cs8 !== model_cs) $display("FAIL bp_checksum got=%h want=%h", cs8, model_cs);
    else passed++;
`endif
  endtask

  task automatic test_clear_collision();
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    @(posedge clock); #1;
    v4 = 1'b1; dat4 = 8'h01;
    @(posedge clock); #1;
    dat4 = 8'h02; clr4 = 1'b1;
    #1;
    total++;
    if (rdy4 !== 1'b0) $display("FAIL clr_ready got=%b want=0", rdy4);
    else passed++;
    @(posedge clock); #1;
    clr4 = 1'b0; v4 = 1'b0;
    total++;
    if (cnt4 !== 7'd0 || ld4 !== 1'b0)
      $display("FAIL clr_count count=%0d loaded=%b want 0/0", cnt4, ld4);
    else passed++;
`ifdef LRAM_LOADER_CHECKSUM_EN
    total++;
    if (cs4 !== 8'h00) $display("FAIL clr_checksum got=%h want=00", cs4);
    else passed++;
`endif
    model_cs = 8'h00;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      v4 = 1'b1; dat4 = vals[i];
      exp_q.push_back(vals[i]);
      model_cs ^= vals[i];
    end
    @(posedge clock); #1;
    v4 = 1'b0;
    total++;
    if (ld4 !== 1'b1 || cnt4 !== 7'd4)
      $display("FAIL clr_reload loaded=%b count=%0d want 1/4", ld4, cnt4);
    else passed++;
    for (int k = 0; k < 4; k++) begin
      ra4 = 6'(k); #1;
      e = exp_q.pop_front();
      total++;
      if (rd4 !== e) $display("FAIL clr_read addr=%0d got=%h want=%h", k, rd4, e);
      else passed++;
    end
`ifdef LRAM_LOADER_CHECKSUM_EN
    total++;
    if (cs4 !== model_cs) $display("FAIL clr_checksum_reload got=%h want=%h", cs4, model_cs);
    else passed++;
`endif
  endtask

  task automatic test_read_before_write();
    @(posedge clock); #1;
    clr4 = 1'b1;
    @(posedge clock); #1;
    clr4 = 1'b0; ra4 = 6'd0; v4 = 1'b1; dat4 = 8'h5A;
    #1;
    total++;
    if (rd4 !== 8'h11) $display("FAIL rbw_old got=%h want=11", rd4);
    else passed++;
    @(posedge clock); #1;
    v4 = 1'b0;
    total++;
    if (rd4 !== 8'h5A) $display("FAIL rbw_new got=%h want=5a", rd4);
    else passed++;
  endtask

  task automatic test_async_reset();
    @(posedge clock); #1;
    clr8 = 1'b1;
    @(posedge clock); #1;
    clr8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      v8 = 1'b1; dat8 = 8'hC0 + 8'(i);
    end
    @(posedge clock); #1;
    v8 = 1'b0;
    total++;
    if (cnt8 !== 7'd3) $display("FAIL ar_partial count=%0d want=3", cnt8);
    else passed++;
    #2 reset = 1'b0;
    #1;
    total++;
    if (cnt8 !== 7'd0 || ld8 !== 1'b0 || rdy8 !== 1'b0)
      $display("FAIL ar_immediate count=%0d loaded=%b ready=%b want 0/0/0", cnt8, ld8, rdy8);
    else passed++;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1; v8 = 1'b1; dat8 = 8'hD7;
    @(posedge clock); #1;
    v8 = 1'b0; ra8 = 6'd0;
    #1;
    total++;
    if (rd8 !== 8'hD7 || cnt8 !== 7'd1)
      $display("FAIL ar_first_beat rd=%h count=%0d want d7/1", rd8, cnt8);
    else passed++;
    ra8 = 6'd1;
    #1;
    total++;
    if (rd8 !== 8'hC1) $display("FAIL ar_mem_kept got=%h want=c1", rd8);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_backpressure();
    test_clear_collision();
    test_read_before_write();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lram_loader.md
# lram_loader

Write-side companion to the LUTRAM ROM blocks. It accepts a valid/ready byte stream and writes it sequentially into a 64×8 distributed (LUTRAM) memory. Once `DEPTH` bytes have been written, it raises `loaded` and stops accepting data. The contents stay readable at all times through an asynchronous read port, so the memory behaves like a runtime-loaded ROM in place of an `INIT_*`-configured one.

## Interface
- `DEPTH`, default 64: number of bytes to load before `loaded` asserts; legal range 1..64.
- `clock`  input  1: sole clock; all state updates on its rising edge.
- `reset`  input  1: asynchronous, active-low; asserts immediately, is released synchronously by the upstream reset bridge.
- `clear`  input  1: synchronous restart of loading; memory contents are kept.
- `in_valid`  input  1: `in_data` is valid.
- `in_ready`  output  1: loader accepts a beat this cycle.
- `in_data`  input  8: byte to write.
- `rd_addr`  input  6: read address.
- `rd_data`  output  8: `mem[rd_addr]`, combinational.
- `loaded`  output  1: `DEPTH` bytes written since reset/clear.
- `count`  output  7: bytes written since reset/clear, 0..`DEPTH`.
- `checksum`  output  8: present only with `LRAM_LOADER_CHECKSUM_EN`.

## Operation
- FSM has two states, LOAD and FULL; reset state is LOAD.
- Reset values: `wr_ptr`=0, `count`=0, `loaded`=0, `checksum`=0.
- `in_ready` = (state==LOAD) & ~`clear`. Reset is low so it reads 0 during reset and 1 right after release.
- Accept = `in_valid` & `in_ready`. On accept:
  - `mem[wr_ptr]` <= `in_data`
  - `wr_ptr` increments
  - `count` increments
- LOAD→FULL: on the accept where `count`==`DEPTH`-1. `loaded` becomes 1 and `in_ready` becomes 0 from the next cycle.
- FULL: ignores `in_valid`; holds `wr_ptr`, `count` and memory.
- `clear`=1 (any state) moves to LOAD and resets `wr_ptr`, `count`, `loaded` and `checksum` to 0. A beat presented in the same cycle is not accepted, since `in_ready` is 0.
- Address width is 6 bits. `wr_ptr` never exceeds `DEPTH`-1 because FULL blocks further writes, so there is no wrap. Addresses ≥`DEPTH` hold contents from the previous load or are undefined after power-up.
- `rd_data` has no handshake and is valid for any `rd_addr` at any time, including during load.
- A reset in the middle of a load returns the block to the reset values. Memory contents are not cleared; only the pointers are.
- `in_valid` may drop without a beat having been accepted. Data is only required to be stable while `in_valid`&~`in_ready`.

## Timing
- A write commits at the rising edge of the accept cycle. From that edge, `rd_data` at that address returns the new byte.
- A read of the address being written in the accept cycle returns the old byte (read-before-write).
- `count`, `loaded` and `checksum` are registered and update at the edge ending the accept cycle.
- `in_ready` is combinational from state and `clear`; it has no combinational path from `in_valid`.
- Throughput is one byte per cycle. A full load takes `DEPTH` cycles with back-to-back valid.

## Configuration
- `LRAM_LOADER_CHECKSUM_EN` defined: the `checksum` port exists.
  - It is a registered running XOR of every accepted byte.
  - It resets to 0 and is cleared by `clear`.
  - It is final once `loaded`=1.
- Not defined: the `checksum` port and its register are absent. All other behaviour is identical.

## Structure
- Package `lram_pkg` holds:
  - `LRAM_DEPTH_MAX`=64
  - `LRAM_AW`=6
  - `LRAM_DW`=8
  - the state enum `lram_ld_state_t` {LOAD, FULL}
- Sub-module `lram_dp64x8` contains the storage: one synchronous write port, one asynchronous read port, with no reset on the array. It is a behavioural model that maps to distributed RAM such as RAM64M8/RAM64X1D; it does not instantiate the primitive directly.
- The top level holds the FSM, the pointer/count logic and the optional checksum.

## Test plan
- Reset check: reset low for 3 cycles, then release → `in_ready`=1, `loaded`=0, `count`=0; with `LRAM_LOADER_CHECKSUM_EN`, `checksum`=0.
- Full load: `DEPTH`=64, send bytes 0x00..0x3F back-to-back → `loaded`=1 exactly one edge after the 64th beat, `count`=64, `in_ready`=0, `rd_data` at addr k = k for all k. With checksum enabled, `checksum`=0x00.
- Backpressure and gaps: `DEPTH`=8, `in_valid` toggling 1/0 with data 0xA0+i, and a 9th beat offered while FULL → `count`=8, memory addr 0..7 = 0xA0..0xA7, 9th beat never accepted.
- Clear collision: `DEPTH`=4, assert `clear` together with `in_valid` on beat 2 → `in_ready`=0 that cycle, `count`=0 next cycle. A reload of 0x11,0x22,0x33,0x44 reads back correctly.
- Read-before-write: `rd_addr`=0 while writing 0x5A to addr 0 → `rd_data`=old value during the accept cycle, 0x5A after the edge.
- Async reset mid-load: drop `reset` after 3 of 8 beats → `count`=0 and `loaded`=0 immediately. After release, the first beat is written to addr 0.
